// File: rtl/lieat_dcache_axi_bridge.sv
// -----------------------------------------------------------------------------
// lieat_dcache_axi_bridge
//
// Purpose: turns the D-cache's single-beat memory request/response into the
// AR/R/AW/W/B handshakes of the dcache_axi_* port of the AXI master arbiter.
// One transaction is in flight at a time. The request is registered, so no
// req_* input reaches an AXI output combinationally. Address, size, data and
// strobes pass through unchanged; lane alignment happens downstream.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   req_valid/ready/addr/wen/    request from the D-cache (wen: 1=write)
//   req_size/wdata/wstrb
//   rsp_valid/ready/rdata/err    response to the D-cache (rdata is 0 on writes)
//   dcache_axi_ar*/r*            AXI read address / read data channels
//   dcache_axi_aw*/w*/b*         AXI write address / write data / response
//
// Optional feature: define LIEAT_DCACHE_AXI_TIMEOUT_EN to bound every AXI wait
// to TIMEOUT_CYCLES cycles. An expired wait returns rsp_err=1, and the first
// late rvalid/bvalid is then swallowed in IDLE before new requests are taken.
// -----------------------------------------------------------------------------
module lieat_dcache_axi_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [2:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              dcache_axi_arvalid,
    input  logic              dcache_axi_arready,
    output logic [ADDR_W-1:0] dcache_axi_araddr,
    output logic [2:0]        dcache_axi_arsize,
    input  logic              dcache_axi_rvalid,
    output logic              dcache_axi_rready,
    input  logic [DATA_W-1:0] dcache_axi_rdata,
    output logic              dcache_axi_awvalid,
    input  logic              dcache_axi_awready,
    output logic [ADDR_W-1:0] dcache_axi_awaddr,
    output logic [2:0]        dcache_axi_awsize,
    output logic              dcache_axi_wvalid,
    input  logic              dcache_axi_wready,
    output logic [DATA_W-1:0] dcache_axi_wdata,
    output logic [7:0]        dcache_axi_wstrb,
    input  logic              dcache_axi_bvalid,
    output logic              dcache_axi_bready,
    input  logic [1:0]        dcache_axi_bresp
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WR   = 3'd3,
        ST_B    = 3'd4,
        ST_RSP  = 3'd5
    } state_e;

    state_e            state_q;
    logic              req_ready_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              aw_done_q;
    logic              w_done_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wstrb_q;

    // Handshakes that move the FSM out of one of its waiting states.
    logic aw_fire_s, w_fire_s, aw_now_s, w_now_s;
    logic ar_fire_s, r_fire_s, wr_done_s, b_fire_s, leave_s;
    logic tmo_hit_s, drain_s;

    assign ar_fire_s = (state_q == ST_AR) && arvalid_q && dcache_axi_arready;
    assign r_fire_s  = (state_q == ST_R)  && rready_q  && dcache_axi_rvalid;
    assign aw_fire_s = awvalid_q && dcache_axi_awready;
    assign w_fire_s  = wvalid_q  && dcache_axi_wready;
    // A channel counts as done if it finished earlier or finishes this cycle.
    assign aw_now_s  = aw_done_q || aw_fire_s;
    assign w_now_s   = w_done_q  || w_fire_s;
    assign wr_done_s = (state_q == ST_WR) && aw_now_s && w_now_s;
    assign b_fire_s  = (state_q == ST_B)  && bready_q  && dcache_axi_bvalid;
    assign leave_s   = ar_fire_s || r_fire_s || wr_done_s || b_fire_s;

`ifdef LIEAT_DCACHE_AXI_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             drain_q;
    logic             waiting_s;

    assign waiting_s = (state_q == ST_AR) || (state_q == ST_R) ||
                       (state_q == ST_WR) || (state_q == ST_B);
    // tmo_cnt_q holds the cycles already spent, so this is the last allowed one.
    assign tmo_hit_s = waiting_s && !leave_s && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drain_s   = drain_q;

    // Wait-cycle counter: zero outside waiting states and on every state change.
    always_ff @(posedge clock) begin
        if (reset || !waiting_s || leave_s) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    // Remembers that an abandoned AXI response may still arrive.
    always_ff @(posedge clock) begin
        if (reset) begin
            drain_q <= 1'b0;
        end else if (tmo_hit_s) begin
            drain_q <= 1'b1;
        end else if ((state_q == ST_IDLE) &&
                     ((rready_q && dcache_axi_rvalid) || (bready_q && dcache_axi_bvalid))) begin
            drain_q <= 1'b0;
        end else begin
            drain_q <= drain_q;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign drain_s   = 1'b0;

    // The limit only matters when the timeout is compiled in; referencing it
    // keeps the parameter list identical in both builds.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
    end
`endif

    // Transaction FSM with all handshake and response outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            size_q      <= 3'd0;
            wdata_q     <= '0;
            wstrb_q     <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (drain_s) begin
                        // Swallow the late response, then reopen the request port.
                        if ((rready_q && dcache_axi_rvalid) || (bready_q && dcache_axi_bvalid)) begin
                            rready_q    <= 1'b0;
                            bready_q    <= 1'b0;
                            req_ready_q <= 1'b1;
                        end
                    end else if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        if (req_wen) begin
                            state_q   <= ST_WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (ar_fire_s) begin
                        state_q   <= ST_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                ST_R: begin
                    if (r_fire_s) begin
                        state_q     <= ST_RSP;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= dcache_axi_rdata;
                        rsp_err_q   <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (aw_fire_s) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_fire_s) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (wr_done_s) begin
                        state_q  <= ST_B;
                        bready_q <= 1'b1;
                    end
                end
                ST_B: begin
                    if (b_fire_s) begin
                        state_q     <= ST_RSP;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= (dcache_axi_bresp != 2'b00);
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        // After a timeout, IDLE first drains the stray response.
                        req_ready_q <= !drain_s;
                        rready_q    <= drain_s;
                        bready_q    <= drain_s;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Abandon the wait; the leave_s term in tmo_hit_s gives handshakes priority.
            if (tmo_hit_s) begin
                state_q     <= ST_RSP;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign req_ready          = req_ready_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_err            = rsp_err_q;
    assign dcache_axi_arvalid = arvalid_q;
    assign dcache_axi_araddr  = addr_q;
    assign dcache_axi_arsize  = size_q;
    assign dcache_axi_rready  = rready_q;
    assign dcache_axi_awvalid = awvalid_q;
    assign dcache_axi_awaddr  = addr_q;
    assign dcache_axi_awsize  = size_q;
    assign dcache_axi_wvalid  = wvalid_q;
    assign dcache_axi_wdata   = wdata_q;
    assign dcache_axi_wstrb   = wstrb_q;
    assign dcache_axi_bready  = bready_q;

endmodule

// File: tb/tb_lieat_dcache_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_lieat_dcache_axi_bridge
//
// Directed bench for lieat_dcache_axi_bridge. Inputs are driven and outputs
// sampled 1 ns after each rising edge. The AXI slave side is played by the
// stimulus itself, cycle by cycle, with hand-computed expected values.
// The timeout scenario is compiled only with LIEAT_DCACHE_AXI_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_lieat_dcache_axi_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [2:0]  req_size;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic [63:0] rdata, wdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp;

    int n_vec = 0;
    int n_err = 0;

    lieat_dcache_axi_bridge #(
        .ADDR_W        (32),
        .DATA_W        (64),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_wen           (req_wen),
        .req_size          (req_size),
        .req_wdata         (req_wdata),
        .req_wstrb         (req_wstrb),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .dcache_axi_arvalid(arvalid),
        .dcache_axi_arready(arready),
        .dcache_axi_araddr (araddr),
        .dcache_axi_arsize (arsize),
        .dcache_axi_rvalid (rvalid),
        .dcache_axi_rready (rready),
        .dcache_axi_rdata  (rdata),
        .dcache_axi_awvalid(awvalid),
        .dcache_axi_awready(awready),
        .dcache_axi_awaddr (awaddr),
        .dcache_axi_awsize (awsize),
        .dcache_axi_wvalid (wvalid),
        .dcache_axi_wready (wready),
        .dcache_axi_wdata  (wdata),
        .dcache_axi_wstrb  (wstrb),
        .dcache_axi_bvalid (bvalid),
        .dcache_axi_bready (bready),
        .dcache_axi_bresp  (bresp)
    );

    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_vec({tag, "_req_ready"}, req_ready, 64'd1);
        check_vec({tag, "_arvalid"},   arvalid,   64'd0);
        check_vec({tag, "_awvalid"},   awvalid,   64'd0);
        check_vec({tag, "_wvalid"},    wvalid,    64'd0);
        check_vec({tag, "_rready"},    rready,    64'd0);
        check_vec({tag, "_bready"},    bready,    64'd0);
        check_vec({tag, "_rsp_valid"}, rsp_valid, 64'd0);
    endtask

    // Read with arready and rvalid at minimum latency; entered in cycle T.
    task automatic read_fast(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d);
        req_valid = 1'b1; req_addr = a; req_wen = 1'b0; req_size = sz;
        check_vec("rd_req_ready", req_ready, 64'd1);
        tick;                                   // T+1
        req_valid = 1'b0;
        check_vec("rd_arvalid", arvalid, 64'd1);
        check_vec("rd_araddr",  araddr,  {32'd0, a});
        check_vec("rd_arsize",  arsize,  {61'd0, sz});
        check_vec("rd_req_ready_busy", req_ready, 64'd0);
        arready = 1'b1;
        tick;                                   // T+2
        arready = 1'b0;
        check_vec("rd_arvalid_drop", arvalid, 64'd0);
        check_vec("rd_rready", rready, 64'd1);
        check_vec("rd_rsp_early", rsp_valid, 64'd0);
        rvalid = 1'b1; rdata = d;
        tick;                                   // T+3
        rvalid = 1'b0; rdata = 64'd0;
        check_vec("rd_rsp_valid", rsp_valid, 64'd1);
        check_vec("rd_rsp_rdata", rsp_rdata, d);
        check_vec("rd_rsp_err",   rsp_err,   64'd0);
        check_vec("rd_rready_drop", rready,  64'd0);
        rsp_ready = 1'b1;
        tick;                                   // T+4
        rsp_ready = 1'b0;
        check_idle("rd_done");
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_wen = 1'b0;
        req_size = 3'd0; req_wdata = 64'd0; req_wstrb = 8'd0; rsp_ready = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = 64'd0; awready = 1'b0;
        wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        tick;
        tick;
        reset = 1'b0;
        check_idle("reset");
        check_vec("reset_rdata", rsp_rdata, 64'd0);
        check_vec("reset_err",   rsp_err,   64'd0);

        // 1: read at minimum latency.
        read_fast(32'h8000_0010, 3'd3, 64'h1122_3344_5566_7788);

        // 2: read with arready held off for 4 cycles, and a stray rvalid meanwhile.
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_wen = 1'b0; req_size = 3'd3;
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_vec("dly_arvalid", arvalid, 64'd1);
            check_vec("dly_araddr",  araddr,  64'h8000_0010);
            check_vec("dly_arsize",  arsize,  64'd3);
            check_vec("dly_rready",  rready,  64'd0);
            rvalid = (i == 1);
            rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            arready = (i == 4);
            tick;
        end
        arready = 1'b0; rvalid = 1'b0;
        check_vec("dly_arvalid_drop", arvalid, 64'd0);
        check_vec("dly_rready", rready, 64'd1);
        tick;
        check_vec("dly_rsp_wait", rsp_valid, 64'd0);
        rvalid = 1'b1; rdata = 64'hDEAD_BEEF_CAFE_F00D;
        tick;
        rvalid = 1'b0;
        check_vec("dly_rsp_valid", rsp_valid, 64'd1);
        check_vec("dly_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check_idle("dly_done");

        // 3: write, wready three cycles before awready, bresp OKAY.
        req_valid = 1'b1; req_addr = 32'h8000_0020; req_wen = 1'b1; req_size = 3'd2;
        req_wdata = 64'hA5A5_0000_5A5A_FFFF; req_wstrb = 8'hF0;
        tick;                                   // T+1
        req_valid = 1'b0;
        check_vec("wr_awvalid", awvalid, 64'd1);
        check_vec("wr_wvalid",  wvalid,  64'd1);
        check_vec("wr_awaddr",  awaddr,  64'h8000_0020);
        check_vec("wr_awsize",  awsize,  64'd2);
        check_vec("wr_wdata",   wdata,   64'hA5A5_0000_5A5A_FFFF);
        check_vec("wr_wstrb",   wstrb,   64'hF0);
        wready = 1'b1;
        tick;                                   // T+2
        wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_vec("wr_wvalid_drop", wvalid,  64'd0);
            check_vec("wr_awvalid_hold", awvalid, 64'd1);
            check_vec("wr_bready_early", bready, 64'd0);
            awready = (i == 2);
            tick;
        end
        awready = 1'b0;                         // T+5
        check_vec("wr_awvalid_drop", awvalid, 64'd0);
        check_vec("wr_bready", bready, 64'd1);
        bvalid = 1'b1; bresp = 2'b00;
        tick;                                   // T+6
        bvalid = 1'b0;
        check_vec("wr_rsp_valid", rsp_valid, 64'd1);
        check_vec("wr_rsp_err",   rsp_err,   64'd0);
        check_vec("wr_rsp_rdata", rsp_rdata, 64'd0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check_idle("wr_done");

        // 4: write with both handshakes together, SLVERR, rsp_ready late.
        req_valid = 1'b1; req_addr = 32'h8000_0040; req_wen = 1'b1; req_size = 3'd3;
        req_wdata = 64'h0123_4567_89AB_CDEF; req_wstrb = 8'hFF;
        tick;                                   // T+1
        req_valid = 1'b0;
        awready = 1'b1; wready = 1'b1;
        tick;                                   // T+2
        awready = 1'b0; wready = 1'b0;
        check_vec("err_awvalid", awvalid, 64'd0);
        check_vec("err_wvalid",  wvalid,  64'd0);
        check_vec("err_bready",  bready,  64'd1);
        bvalid = 1'b1; bresp = 2'b10;
        tick;                                   // T+3
        bvalid = 1'b0; bresp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check_vec("err_rsp_valid", rsp_valid, 64'd1);
            check_vec("err_rsp_err",   rsp_err,   64'd1);
            check_vec("err_req_ready", req_ready, 64'd0);
            rsp_ready = (i == 3);
            tick;
        end
        rsp_ready = 1'b0;
        check_idle("err_done");

        // 5: reset in the middle of WR.
        req_valid = 1'b1; req_addr = 32'h8000_0080; req_wen = 1'b1;
        tick;
        req_valid = 1'b0;
        check_vec("rst_awvalid", awvalid, 64'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_idle("rst_mid");
        read_fast(32'h8000_0100, 3'd2, 64'h0000_0000_CAFE_BABE);

`ifdef LIEAT_DCACHE_AXI_TIMEOUT_EN
        // 6: arready never comes; timeout after 8 AR cycles, then drain.
        req_valid = 1'b1; req_addr = 32'h8000_0200; req_wen = 1'b0; req_size = 3'd3;
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_vec("tmo_arvalid", arvalid, 64'd1);
            tick;
        end
        check_vec("tmo_arvalid_drop", arvalid, 64'd0);
        check_vec("tmo_rsp_valid", rsp_valid, 64'd1);
        check_vec("tmo_rsp_err",   rsp_err,   64'd1);
        check_vec("tmo_rsp_rdata", rsp_rdata, 64'd0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check_vec("drn_req_ready", req_ready, 64'd0);
        check_vec("drn_rready",    rready,    64'd1);
        check_vec("drn_bready",    bready,    64'd1);
        tick;
        check_vec("drn_req_ready_hold", req_ready, 64'd0);
        rvalid = 1'b1; rdata = 64'h7777_7777_7777_7777;
        tick;
        rvalid = 1'b0;
        check_vec("drn_req_ready_back", req_ready, 64'd1);
        check_vec("drn_rready_drop",    rready,    64'd0);
        check_vec("drn_rsp_valid",      rsp_valid, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
